sobel_window_gen: RTL and testbench

- Streaming producer of 3x3 pixel windows for the combinational Sobel filter.
- Consumes a raster-order grayscale pixel stream from an input FIFO. Buffers two image lines plus three pixels in a shift register.
- Writes one packed 9-tap window per image pixel to an output FIFO; the Sobel filter stage reads that FIFO.
- Border-centred windows are emitted as all-zero, so the filter produces 0 on image edges.

---
 rtl/sobel_pkg.sv | 9 +
 rtl/sobel_line_shift.sv | 35 +++
 rtl/sobel_window_gen.sv | 106 ++++++++++
 tb/tb_sobel_window_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window generator and the Sobel filter stage.
package sobel_pkg;
  localparam int GRAY_DATA_WIDTH = 8;

  typedef logic [GRAY_DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;
endpackage

// File: rtl/sobel_line_shift.sv
// Two-line-plus-three-pixel shift register exposing the nine 3x3 window taps.
module sobel_line_shift #(
  parameter int WIDTH = 720,
  parameter int DW    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [DW-1:0]       din,
  output logic [8:0][DW-1:0]  taps
);
  localparam int DEPTH = 2*WIDTH + 3;

  logic [DW-1:0] sr [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // Oldest pixels sit at the high end, so the top-left tap is the deepest stage.
  assign taps[8] = sr[0];
  assign taps[7] = sr[1];
  assign taps[6] = sr[2];
  assign taps[5] = sr[WIDTH];
  assign taps[4] = sr[WIDTH+1];
  assign taps[3] = sr[WIDTH+2];
  assign taps[2] = sr[2*WIDTH];
  assign taps[1] = sr[2*WIDTH+1];
  assign taps[0] = sr[2*WIDTH+2];
endmodule

// File: rtl/sobel_window_gen.sv
// Streams raster pixels in and one 3x3 window per pixel out; border-centred windows are zero.
// state   | meaning
// S_FILL  | pop WIDTH+2 pixels to prime the line buffer, no writes
// S_RUN   | pop and write together, one window per fire
// S_FLUSH | shift zeros in and write the trailing WIDTH+2 windows
module sobel_window_gen #(
  parameter int GRAY_DATA_WIDTH = sobel_pkg::GRAY_DATA_WIDTH,
  parameter int WIDTH           = 720,
  parameter int HEIGHT          = 540
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [GRAY_DATA_WIDTH-1:0]       in_dout,
  input  logic                             in_empty,
  output logic                             in_rd_en,
  output logic [8:0][GRAY_DATA_WIDTH-1:0]  out_din,
  input  logic                             out_full,
  output logic                             out_wr_en
);
  import sobel_pkg::*;

  localparam int CNT_W = $clog2(WIDTH*HEIGHT);
  localparam int RW    = $clog2(HEIGHT);
  localparam int CW    = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(WIDTH*HEIGHT - WIDTH - 3);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(WIDTH - 1);

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 cnt, cnt_last;
  logic [RW-1:0]                    row;
  logic [CW-1:0]                    col;
  logic                             step, last_step, border;
  logic [GRAY_DATA_WIDTH-1:0]       shift_din;
  logic [8:0][GRAY_DATA_WIDTH-1:0]  taps;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (last_step) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_FLUSH;
      S_FLUSH: if (last_step) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // Handshakes are gated by reset so nothing moves while it is held.
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    cnt_last  = FILL_LAST;
    if (!reset) begin
      case (state)
        S_FILL:  in_rd_en = !in_empty;
        S_RUN: begin
          in_rd_en  = !in_empty && !out_full;
          out_wr_en = !in_empty && !out_full;
        end
        S_FLUSH: out_wr_en = !out_full;
        default: ;
      endcase
    end
    if (state == S_RUN) cnt_last = RUN_LAST;
  end

  assign step      = in_rd_en || out_wr_en;
  assign last_step = step && (cnt == cnt_last);
  assign shift_din = (state == S_FLUSH) ? '0 : in_dout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      row <= '0;
      col <= '0;
    end else begin
      if (step) cnt <= last_step ? '0 : cnt + CNT_W'(1);
      // The final flush write wraps the centre back to (0,0) for the next frame.
      if (out_wr_en) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  sobel_line_shift #(.WIDTH(WIDTH), .DW(GRAY_DATA_WIDTH)) u_line_shift (
    .clock    (clock),
    .reset    (reset),
    .shift_en (step),
    .din      (shift_din),
    .taps     (taps)
  );

  assign border  = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign out_din = border ? '0 : taps;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x4 image with stall, back-to-back and reset cases.
module tb_sobel_window_gen;
  typedef logic [8:0][7:0] win_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_dout = '0;
  logic       in_empty = 1'b1;
  logic       out_full = 1'b0;
  logic       in_rd_en, out_wr_en;
  win_t       out_din;

  logic [7:0] fifo[$];
  win_t       exp_q[$];
  win_t       cap[$];
  int         checks = 0, failures = 0;
  int         n_wr = 0, n_pop = 0;
  bit         ignore_wr = 1'b0;

  sobel_window_gen #(.GRAY_DATA_WIDTH(8), .WIDTH(4), .HEIGHT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_din   (out_din),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic win_t mk(input int a[9]);
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = a[k][7:0];
    return w;
  endfunction

  function automatic int sobel(input win_t w);
    int h, v;
    h = (int'(w[2]) + 2*int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[3]) + int'(w[6]));
    v = (int'(w[6]) + 2*int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[1]) + int'(w[2]));
    if (h < 0) h = -h;
    if (v < 0) v = -v;
    return (h + v) / 2;
  endfunction

  // Expected window from 2D image coordinates of a frame whose pixels are base+1..base+16.
  function automatic win_t exp_win(input int base, input int r, input int c);
    win_t w = '0;
    if (r > 0 && r < 3 && c > 0 && c < 3)
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          w[dr*3+dc] = 8'(base + (r-1+dr)*4 + (c-1+dc) + 1);
    return w;
  endfunction

  task automatic push_frame(input int base);
    for (int i = 0; i < 16; i++) fifo.push_back(8'(base + i + 1));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(exp_win(base, r, c));
  endtask

  // mode 0: no stalls, 1: in_empty every other cycle, 2: out_full for 5 cycles in S_RUN
  task automatic run(input int mode, input int budget, input string name);
    int cyc = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clock);
      in_empty = (fifo.size() == 0) || (mode == 1 && (cyc % 2) == 1);
      in_dout  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      out_full = (mode == 2) && (cyc >= 8) && (cyc < 13);
      #4;
      if (out_full) chk({name, "_stall_hs"}, {70'b0, in_rd_en, out_wr_en}, 72'd0);
      if (in_rd_en) begin
        void'(fifo.pop_front());
        n_pop++;
      end
      cyc++;
    end
    if (cyc >= budget) chk({name, "_timeout"}, 72'(cyc), 72'(budget - 1));
    @(negedge clock);
    in_empty = 1'b1;
    out_full = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      #4;
      if (!reset) begin
        chk("rd_while_empty", {71'b0, in_rd_en & in_empty}, 72'd0);
        chk("wr_while_full", {71'b0, out_wr_en & out_full}, 72'd0);
        if (out_wr_en && !ignore_wr) begin
          n_wr++;
          cap.push_back(out_din);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=none", out_din);
          end else begin
            chk("window", out_din, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic frame_test(input int mode, input string name);
    int w0, p0;
    logic [15:0] nz;
    cap.delete();
    w0 = n_wr;
    p0 = n_pop;
    push_frame(0);
    run(mode, 300, name);
    chk({name, "_writes"}, 72'(n_wr - w0), 72'd16);
    chk({name, "_pops"}, 72'(n_pop - p0), 72'd16);
    nz = '0;
    for (int i = 0; i < 16 && i < cap.size(); i++) nz[i] = (cap[i] != '0);
    chk({name, "_nonzero_map"}, 72'(nz), 72'h0660);
    chk({name, "_win5"}, (cap.size() > 5) ? cap[5] : '0, mk('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
    chk({name, "_win6"}, (cap.size() > 6) ? cap[6] : '0, mk('{2, 3, 4, 6, 7, 8, 10, 11, 12}));
  endtask

  initial begin : stim
    reset    = 1'b1;
    in_empty = 1'b0;
    repeat (2) begin
      @(negedge clock);
      #4;
      chk("reset_hs", {70'b0, in_rd_en, out_wr_en}, 72'd0);
      chk("reset_out_din", out_din, 72'd0);
    end
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;

    frame_test(0, "plain");
    chk("sobel_win6", 72'((cap.size() > 6) ? sobel(cap[6]) : -1), 72'd20);

    frame_test(2, "out_stall");
    frame_test(1, "in_toggle");

    cap.delete();
    push_frame(0);
    push_frame(100);
    run(0, 400, "b2b");
    chk("b2b_writes", 72'(cap.size()), 72'd32);
    chk("b2b_f2_win5", (cap.size() > 21) ? cap[21] : '0,
        mk('{101, 102, 103, 105, 106, 107, 109, 110, 111}));

    // Abort a frame after 7 pixels, then check the next frame starts clean.
    ignore_wr = 1'b1;
    for (int i = 0; i < 7; i++) fifo.push_back(8'(i + 1));
    run(0, 50, "partial");
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    in_dout  = 8'h55;
    repeat (3) begin
      #4;
      chk("midreset_hs", {70'b0, in_rd_en, out_wr_en}, 72'd0);
      @(negedge clock);
    end
    reset    = 1'b0;
    in_empty = 1'b1;
    fifo.delete();
    exp_q.delete();
    @(negedge clock);
    ignore_wr = 1'b0;
    frame_test(0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
